// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state, coin values and price lookup for vend_ctrl
// No ports; imported by vend_ctrl and vend_change.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  localparam int COIN_ONE = 1;
  localparam int COIN_FIVE = 5;
  localparam int COIN_TEN = 10;
  // Channel 0 sits in the leftmost slice of PRICES, so {p0,p1,...} reads in channel order.
  function automatic logic [31:0] price_slice(input logic [255:0] prices, input int nch, input int w, input int idx);
    logic [255:0] mask;
    mask = (256'd1 << w) - 256'd1;
    return 32'((prices >> ((nch - 1 - idx) * w)) & mask);
  endfunction
endpackage

// File: rtl/vend_change.sv
// vend_change: greedy coin picker, largest of 10/5/1 not above the remaining credit
// Ports: credit (in, remaining credit), coin (out, value of the next coin to dispense, 0 if none).
module vend_change
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] credit,
  output logic [W-1:0] coin
);
  always_comb
    coin = (int'(credit) >= COIN_TEN)  ? W'(COIN_TEN)  :
           (int'(credit) >= COIN_FIVE) ? W'(COIN_FIVE) :
           (credit != '0)              ? W'(COIN_ONE)  : '0;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: NCH-channel coin vending controller with per-channel price and stock
// Ports: clk/rst_n (async active-low); one/fine/ten coin pulses; sel one-hot select;
// sure confirm; cancel refund; restock reload; money credit; have_good stock!=0;
// put vend pulse; put_money/change refund strobe and amount; coin_rej, err pulses; busy.
// Define VEND_COIN_CHANGE_EN to refund one 10/5/1 coin per cycle instead of a lump sum.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CREDIT_W = 8,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 5,
  parameter logic [NCH*CREDIT_W-1:0] PRICES = {8'd6, 8'd2, 8'd6, 8'd2}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                one,
  input  logic                fine,
  input  logic                ten,
  input  logic [NCH-1:0]      sel,
  input  logic                sure,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] money,
  output logic [NCH-1:0]      have_good,
  output logic [NCH-1:0]      put,
  output logic                put_money,
  output logic [CREDIT_W-1:0] change,
  output logic                coin_rej,
  output logic                err,
  output logic                busy
);
  typedef logic [CREDIT_W+4:0] wide_t;
  localparam int SMAX = (1 << STOCK_W) - 1;
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'((STOCK_INIT > SMAX) ? SMAX : STOCK_INIT);
  localparam wide_t CMAX = wide_t'({CREDIT_W{1'b1}});
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, credit_acc, price_sel, coin_val;
  logic [NCH-1:0] sel_q, sel_d;
  logic coin_rej_q, coin_rej_d, err_q, err_d, busy_q, busy_d;
  logic coin_any, accept, sel_ok;
  wide_t coin_sum, sum;
  assign coin_any = one | fine | ten;
  assign coin_sum = (one ? wide_t'(COIN_ONE) : '0) + (fine ? wide_t'(COIN_FIVE) : '0) + (ten ? wide_t'(COIN_TEN) : '0);
  assign sum = wide_t'(credit_q) + coin_sum;
  assign accept = sum <= CMAX;
  assign credit_acc = accept ? CREDIT_W'(sum) : credit_q;
  assign sel_ok = $onehot(sel) && ((sel & have_good) != '0);
`ifdef VEND_COIN_CHANGE_EN
  vend_change #(.W(CREDIT_W)) u_change (.credit(credit_q), .coin(coin_val));
`else
  assign coin_val = credit_q;
`endif
  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NCH; i++)
      if (sel_q[i]) price_sel |= CREDIT_W'(price_slice(256'(PRICES), NCH, CREDIT_W, i));
  end
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    sel_d = sel_q;
    coin_rej_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        credit_d = credit_acc;
        coin_rej_d = coin_any && !accept;
        if (coin_any && accept) state_d = COLLECT;
        if (sel_ok) sel_d = sel;
        // cancel outranks sure; the refund includes coins taken this same cycle
        if (cancel) begin
          if (credit_acc != '0) begin
            state_d = CHANGE;
            sel_d = '0;
          end
        end else if (sure) begin
          // purchase is decided on the already-latched selection, not a same-cycle sel
          if (state_q == COLLECT && sel_q != '0 && credit_q >= price_sel) begin
            state_d = VEND;
            sel_d = sel_q;
          end else err_d = 1'b1;
        end
      end
      VEND: begin
        coin_rej_d = coin_any;
        credit_d = credit_q - price_sel;
        sel_d = '0;
        state_d = (credit_q != price_sel) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_rej_d = coin_any;
        credit_d = credit_q - coin_val;
        state_d = (credit_q == coin_val) ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {VEND, CHANGE};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      credit_q <= '0;
      sel_q <= '0;
      coin_rej_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      sel_q <= sel_d;
      coin_rej_q <= coin_rej_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  for (genvar g = 0; g < NCH; g++) begin : g_stock
    logic [STOCK_W-1:0] stock_q, stock_d;
    // a reload in the same cycle as a vend wins over the decrement
    always_comb stock_d = restock ? STOCK_RST : (state_q == VEND && sel_q[g]) ? stock_q - STOCK_W'(1) : stock_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stock_q <= STOCK_RST;
      else stock_q <= stock_d;
    assign have_good[g] = stock_q != '0;
  end
  assign money = credit_q;
  assign put = (state_q == VEND) ? sel_q : '0;
  assign put_money = state_q == CHANGE;
  assign change = put_money ? coin_val : '0;
  assign coin_rej = coin_rej_q;
  assign err = err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scoreboard bench for vend_ctrl
module tb_vend_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic one = 1'b0, fine = 1'b0, ten = 1'b0, sure = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [3:0] sel = '0;
  logic [7:0] money, change;
  logic [3:0] have_good, put;
  logic put_money, coin_rej, err, busy;
  int errors = 0, checks = 0;
  int exp_put[$];
  int exp_chg[$];
  always #5 clk = ~clk;
  vend_ctrl dut (
    .clk(clk), .rst_n(rst_n), .one(one), .fine(fine), .ten(ten), .sel(sel), .sure(sure),
    .cancel(cancel), .restock(restock), .money(money), .have_good(have_good), .put(put),
    .put_money(put_money), .change(change), .coin_rej(coin_rej), .err(err), .busy(busy)
  );
  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(logic o, logic f, logic t);
    one = o;
    fine = f;
    ten = t;
    step();
    one = 1'b0;
    fine = 1'b0;
    ten = 1'b0;
  endtask
  task automatic pick(logic [3:0] s);
    sel = s;
    step();
    sel = '0;
  endtask
  task automatic push_change(int amt);
    int r, c;
    r = amt;
`ifdef VEND_COIN_CHANGE_EN
    while (r > 0) begin
      c = (r >= 10) ? 10 : (r >= 5) ? 5 : 1;
      exp_chg.push_back(c);
      r -= c;
    end
`else
    c = r;
    exp_chg.push_back(c);
`endif
  endtask
  task automatic buy(int ch);
    exp_put.push_back(ch);
    sure = 1'b1;
    step();
    sure = 1'b0;
  endtask
  task automatic do_cancel(int amt);
    push_change(amt);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask
  task automatic wait_idle(string tag);
    for (int i = 0; i < 40 && busy; i++) step();
    check(tag, busy, 0);
  endtask
  // scoreboard: every vend and refund strobe must match the next queued expectation
  always @(negedge clk) if (rst_n) begin
    if (put != '0) begin
      if (exp_put.size() == 0) check("put_unexpected", put, 0);
      else check("put", put, 1 << exp_put.pop_front());
    end
    if (put_money) begin
      if (exp_chg.size() == 0) check("change_unexpected", put_money, 0);
      else check("change", change, exp_chg.pop_front());
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_money", money, 0);
    check("rst_busy", busy, 0);
    check("rst_have_good", have_good, 4'hF);
    check("rst_put_money", put_money, 0);
    @(negedge clk) rst_n = 1'b1;
    coin(0, 1, 0);
    check("t1_money5", money, 5);
    coin(1, 0, 0);
    check("t1_money6", money, 6);
    pick(4'b0010);
    push_change(4);
    buy(1);
    check("t1_vend_busy", busy, 1);
    check("t1_vend_money", money, 6);
    step();
    check("t1_after_vend_money", money, 4);
    wait_idle("t1_idle");
    check("t1_final_money", money, 0);
    coin(0, 0, 1);
    coin(0, 0, 1);
    check("t2_money20", money, 20);
    pick(4'b0001);
    push_change(14);
    buy(0);
    wait_idle("t2_idle");
    check("t2_final_money", money, 0);
    coin(1, 0, 0);
    pick(4'b0001);
    sure = 1'b1;
    step();
    sure = 1'b0;
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    step();
    check("t3_err_clear", err, 0);
    check("t3_money", money, 1);
    do_cancel(1);
    check("t3_cancel_busy", busy, 1);
    wait_idle("t3_idle");
    check("t3_final_money", money, 0);
    coin(1, 1, 1);
    check("t4_money16", money, 16);
    repeat (23) coin(0, 0, 1);
    repeat (4) coin(1, 0, 0);
    check("t4_money250", money, 250);
    coin(0, 0, 1);
    check("t4_coin_rej", coin_rej, 1);
    check("t4_money_held", money, 250);
    step();
    check("t4_coin_rej_clear", coin_rej, 0);
    do_cancel(250);
    wait_idle("t4_idle");
    for (int k = 0; k < 5; k++) begin
      coin(0, 1, 0);
      coin(1, 0, 0);
      pick(4'b0100);
      buy(2);
      wait_idle("t5_idle");
    end
    check("t5_have_good_empty", have_good, 4'b1011);
    coin(0, 0, 1);
    pick(4'b0100);
    sure = 1'b1;
    step();
    sure = 1'b0;
    check("t5_empty_sel_err", err, 1);
    restock = 1'b1;
    step();
    restock = 1'b0;
    check("t5_restock", have_good, 4'hF);
    pick(4'b0100);
    push_change(10);
    sure = 1'b1;
    cancel = 1'b1;
    step();
    sure = 1'b0;
    cancel = 1'b0;
    check("t6_cancel_wins_busy", busy, 1);
    check("t6_no_put", put, 0);
    wait_idle("t6_idle");
    check("t6_final_money", money, 0);
    coin(0, 1, 0);
    coin(1, 0, 0);
    pick(4'b0011);
    sure = 1'b1;
    step();
    sure = 1'b0;
    check("t6_multihot_err", err, 1);
    do_cancel(6);
    wait_idle("t6_mh_idle");
    coin(0, 0, 1);
    coin(0, 0, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("t7_in_change", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_money", money, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_put_money", put_money, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("t7_after_money", money, 0);
    check("sb_put_left", exp_put.size(), 0);
    check("sb_change_left", exp_chg.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
